plat_spawn_sched: RTL and testbench
===================================

// Module: plat_spawn_sched
// PURPOSE
//  Scheduler that assigns a platform type to each platform slot when it respawns.
//  Slots that scroll off-screen raise respawn_req. The block grants one slot at a
//  time (round-robin), rolls a type from a free-running LFSR weighted by difficulty
//  level, and issues it on type_trigger/type_valid. This output drives the per-slot
//  platform colour register (Green/White/Blue/Yellow/Brown) and a readable type table.
// PARAMETERS
//  NUM_PLAT   10        number of platform slots (2..16)
//  SCORE_W    16        width of score input
//  LVL_STEP   500       score increment per difficulty level
//  LFSR_SEED  16'hACE1  LFSR reset value; 0 is replaced by 16'h0001
// PORTS
//  Clk          in   1              system clock, all flops posedge
//  Reset_n      in   1              asynchronous, active-low reset
//  frame_tick   in   1              one-cycle pulse per video frame
//  score        in   SCORE_W        current game score (unsigned)
//  respawn_req  in   NUM_PLAT       per-slot request; held until respawn_ack
//  respawn_ack  out  NUM_PLAT       one-hot, one-cycle grant-complete pulse
//  slot_idx     out  $clog2(NUM_PLAT)  slot being issued (valid with type_valid)
//  type_trigger out  3              issued type: 000 G,001 W,010 Bl,011 Y,100 Br
//  type_valid   out  1              one-cycle strobe qualifying slot_idx/type_trigger
//  type_table   out  3*NUM_PLAT     last type issued per slot, slot0 in [2:0]
//  level        out  2              current difficulty level 0..3
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, rr ptr=0, level=0, last_type=Green,
//   lfsr=LFSR_SEED, all outputs 0, type_table all Green (000).
//  LFSR: 16-bit Galois, mask 16'hB400, steps every clock; never reaches 0.
//  FSM IDLE -> ROLL -> ISSUE -> IDLE:
//   IDLE : if any unmasked req, latch grant = first set bit searching upward from
//          ptr with wrap; -> ROLL. Else stay.
//   ROLL : r = lfsr[7:0]; map r via the level table below into rolled type; -> ISSUE.
//   ISSUE: type_valid=1, respawn_ack[grant]=1, slot_idx=grant, type_trigger=type,
//          type_table[grant]<=type, last_type<=type, ptr<=grant+1 (wrap to 0 at
//          NUM_PLAT); -> IDLE.
//  Latency: req first seen in IDLE at cycle N -> type_valid/ack in cycle N+2.
//   Throughput is 1 issue per 3 cycles.
//  Mask: in the IDLE cycle directly after ISSUE, the just-acked slot is ignored.
//   This absorbs requester deassert latency.
//  Type table (r ranges inclusive) G / Bl / W / Br / Y:
//   L0: 0-191 / 192-223 / none / none / 224-255
//   L1: 0-127 / 128-175 / 176-207 / 208-239 / 240-255
//   L2: 0-79 / 80-143 / 144-191 / 192-239 / 240-255
//   L3: 0-47 / 48-127 / 128-191 / 192-247 / 248-255
//  Constraint: rolled Brown while last_type==Brown -> issue Green (no two breakable
//   platforms in a row).
//  Level: on frame_tick, if level<3 and score >= (level+1)*LVL_STEP, level<=level+1.
//   Compare in SCORE_W+2 bits. Level rises at most one step per tick, saturates at 3,
//   and never decreases except on reset.
//  A level change while in ROLL takes effect on the next roll, not the current one.
//  Requests dropped before ack are still serviced once latched (grant is committed).
//  frame_tick and FSM activity are independent; both may occur in the same cycle.
//  Reset mid-operation aborts the grant: no ack and no type_valid are produced.
// STRUCTURE
//  Shared package doodle_pkg holds:
//   - plat_type_e enum (Green=0, White, Blue, Yellow, Brown)
//   - sched_state_e enum (IDLE, ROLL, ISSUE)
//   - LFSR_MASK constant
//   - per-level threshold constant arrays
//  Sub-module rr_arbiter: parameter N; inputs req[N], ptr; outputs grant_idx, any.
//   It is purely combinational. The top level owns the FSM, LFSR, level and table.
// TESTING
//  1 Reset: hold Reset_n=0 mid-ISSUE -> all outputs 0, type_table=0, level=0.
//    Release: first type_valid occurs no earlier than 2 cycles after a req.
//  2 Single req slot3 at L0 -> ack[3] and type_valid 2 cycles later, slot_idx=3.
//    type_trigger is in {000,010,011}, never 001 or 100.
//  3 req=all ones, ptr=0 -> grants 0,1,...,9,0 in order, 3 cycles apart.
//    The acked slot is not regranted on the next IDLE cycle.
//  4 Force lfsr so r=200 twice at L2 -> first issue 100 (Brown).
//    Second issue is 000 (Green), due to the no-consecutive-Brown rule.
//  5 score=1600, three frame_ticks -> level steps 1,2,3. A fourth tick stays at 3.
//    score=499 from reset -> level stays 0.
//  6 ack and frame_tick in the same cycle with the level crossing -> the issued type
//    uses the old level table, and level increments correctly.

Source files
------------

// File: rtl/doodle_pkg.sv
// Shared types and tables for the platform respawn scheduler.
package doodle_pkg;

  typedef enum logic [2:0] {
    GREEN  = 3'd0,
    WHITE  = 3'd1,
    BLUE   = 3'd2,
    YELLOW = 3'd3,
    BROWN  = 3'd4
  } plat_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    ISSUE = 2'd2
  } sched_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Inclusive upper roll bound per level; an empty band repeats the previous bound.
  localparam logic [7:0] G_MAX  [4] = '{8'd191, 8'd127, 8'd79,  8'd47};
  localparam logic [7:0] BL_MAX [4] = '{8'd223, 8'd175, 8'd143, 8'd127};
  localparam logic [7:0] W_MAX  [4] = '{8'd223, 8'd207, 8'd191, 8'd191};
  localparam logic [7:0] BR_MAX [4] = '{8'd223, 8'd239, 8'd239, 8'd247};

  function automatic plat_type_e roll_type(input logic [1:0] lvl, input logic [7:0] r);
    plat_type_e t;
    if (r <= G_MAX[lvl]) begin
      t = GREEN;
    end else if (r <= BL_MAX[lvl]) begin
      t = BLUE;
    end else if (r <= W_MAX[lvl]) begin
      t = WHITE;
    end else if (r <= BR_MAX[lvl]) begin
      t = BROWN;
    end else begin
      t = YELLOW;
    end
    return t;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N = 10
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW:0]   sum_s;
  logic [IW-1:0] idx_s;

  // Walk downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    grant_idx = '0;
    sum_s     = '0;
    idx_s     = '0;
    any       = |req;
    for (int i = N - 1; i >= 0; i--) begin
      sum_s     = {1'b0, ptr} + (IW+1)'(i);
      idx_s     = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : IW'(sum_s);
      grant_idx = req[idx_s] ? idx_s : grant_idx;
    end
  end

endmodule

// File: rtl/plat_spawn_sched.sv
// Respawn scheduler: grants one slot at a time and rolls its platform type
// from a free-running LFSR weighted by the difficulty level.
module plat_spawn_sched
  import doodle_pkg::*;
#(
  parameter int          NUM_PLAT  = 10,
  parameter int          SCORE_W   = 16,
  parameter int          LVL_STEP  = 500,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        frame_tick,
  input  logic [SCORE_W-1:0]          score,
  input  logic [NUM_PLAT-1:0]         respawn_req,
  output logic [NUM_PLAT-1:0]         respawn_ack,
  output logic [$clog2(NUM_PLAT)-1:0] slot_idx,
  output logic [2:0]                  type_trigger,
  output logic                        type_valid,
  output logic [3*NUM_PLAT-1:0]       type_table,
  output logic [1:0]                  level
);
  localparam int                 IW     = $clog2(NUM_PLAT);
  localparam logic [15:0]        SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [SCORE_W+1:0] STEP_W = (SCORE_W+2)'(LVL_STEP);

  sched_state_e               state_r;
  logic [IW-1:0]              ptr_r;
  logic [IW-1:0]              grant_r;
  logic [IW-1:0]              grant_s;
  logic                       any_s;
  logic                       mask_r;
  logic [15:0]                lfsr_r;
  plat_type_e                 last_type_r;
  plat_type_e                 type_r;
  plat_type_e                 raw_s;
  plat_type_e                 rolled_s;
  logic [NUM_PLAT-1:0]        grant_oh_s;
  logic [NUM_PLAT-1:0]        req_s;
  logic [SCORE_W+1:0]         lvl_thresh_s;
  logic [NUM_PLAT-1:0][2:0]   table_r;

  assign type_table = table_r;

  // One-hot of the committed grant; also masks that slot in the IDLE cycle after ISSUE.
  always_comb begin
    grant_oh_s          = '0;
    grant_oh_s[grant_r] = 1'b1;
    if (mask_r) begin
      req_s = respawn_req & ~grant_oh_s;
    end else begin
      req_s = respawn_req;
    end
  end

  rr_arbiter #(.N(NUM_PLAT)) u_arb (
    .req       (req_s),
    .ptr       (ptr_r),
    .grant_idx (grant_s),
    .any       (any_s)
  );

  // Roll from the level table, then forbid two breakable platforms in a row.
  always_comb begin
    raw_s = roll_type(level, lfsr_r[7:0]);
    if (raw_s == BROWN && last_type_r == BROWN) begin
      rolled_s = GREEN;
    end else begin
      rolled_s = raw_s;
    end
  end

  // Free-running Galois LFSR; a nonzero seed keeps it off the all-zero state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign lvl_thresh_s = STEP_W * (SCORE_W+2)'(level) + STEP_W;

  // Difficulty rises by at most one step per frame and saturates at 3.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      level <= 2'd0;
    end else if (frame_tick && level != 2'd3 && {2'b00, score} >= lvl_thresh_s) begin
      level <= level + 2'd1;
    end else begin
      level <= level;
    end
  end

  // Scheduler FSM with registered issue outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= IDLE;
      ptr_r        <= '0;
      grant_r      <= '0;
      mask_r       <= 1'b0;
      last_type_r  <= GREEN;
      type_r       <= GREEN;
      table_r      <= '0;
      respawn_ack  <= '0;
      slot_idx     <= '0;
      type_trigger <= 3'b000;
      type_valid   <= 1'b0;
    end else begin
      respawn_ack  <= '0;
      slot_idx     <= '0;
      type_trigger <= 3'b000;
      type_valid   <= 1'b0;
      mask_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_r <= grant_s;
            state_r <= ROLL;
          end else begin
            state_r <= IDLE;
          end
        end
        ROLL: begin
          type_r       <= rolled_s;
          type_trigger <= rolled_s;
          slot_idx     <= grant_r;
          respawn_ack  <= grant_oh_s;
          type_valid   <= 1'b1;
          state_r      <= ISSUE;
        end
        ISSUE: begin
          table_r[grant_r] <= type_r;
          last_type_r      <= type_r;
          ptr_r            <= (grant_r == IW'(NUM_PLAT - 1)) ? '0 : grant_r + IW'(1);
          mask_r           <= 1'b1;
          state_r          <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plat_spawn_sched.sv
// Scoreboard bench for plat_spawn_sched against a transaction-level reference model.
module tb_plat_spawn_sched;
  localparam int N = 10;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic [15:0]   score = '0;
  logic [N-1:0]  respawn_req = '0;
  logic [N-1:0]  respawn_ack;
  logic [3:0]    slot_idx;
  logic [2:0]    type_trigger;
  logic          type_valid;
  logic [3*N-1:0] type_table;
  logic [1:0]    level;

  plat_spawn_sched #(.NUM_PLAT(N), .SCORE_W(16), .LVL_STEP(500), .LFSR_SEED(16'hACE1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .score(score),
    .respawn_req(respawn_req), .respawn_ack(respawn_ack), .slot_idx(slot_idx),
    .type_trigger(type_trigger), .type_valid(type_valid), .type_table(type_table),
    .level(level)
  );

  always #5 Clk = ~Clk;

  typedef struct { int slot; int typ; int cyc; } exp_t;
  exp_t exp_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  bit model_en = 1'b1;
  int m_level, m_ptr, m_last, m_free, m_mask_cyc, m_mask_slot;
  logic [15:0] m_lfsr;
  int exp_table[N];

  task automatic check(input string name, input longint act, input longint expv);
    chk_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Type codes: 0 Green, 1 White, 2 Blue, 3 Yellow, 4 Brown.
  function automatic int ref_type(input int lvl, input int r);
    case (lvl)
      0: begin
        if (r < 192) return 0; else if (r < 224) return 2; else return 3;
      end
      1: begin
        if (r < 128) return 0; else if (r < 176) return 2; else if (r < 208) return 1;
        else if (r < 240) return 4; else return 3;
      end
      2: begin
        if (r < 80) return 0; else if (r < 144) return 2; else if (r < 192) return 1;
        else if (r < 240) return 4; else return 3;
      end
      default: begin
        if (r < 48) return 0; else if (r < 128) return 2; else if (r < 192) return 1;
        else if (r < 248) return 4; else return 3;
      end
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3*N-1:0] pack_tbl();
    logic [3*N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[3*i +: 3] = exp_table[i][2:0];
    return v;
  endfunction

  task automatic model_reset();
    m_level = 0; m_ptr = 0; m_last = 0; m_free = 0;
    m_mask_cyc = -10; m_mask_slot = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic push_exp(input int slot, input int typ, input int c);
    exp_t e;
    e.slot = slot; e.typ = typ; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Reference model: one grant per 3 cycles, round-robin, LFSR-weighted roll.
  initial begin
    int g, r, t, s;
    model_reset();
    forever begin
      @(posedge Clk);
      cyc++;
      if (!Reset_n) begin
        model_reset();
      end else begin
        if (frame_tick && m_level < 3 && int'(score) >= (m_level + 1) * 500) m_level++;
        m_lfsr = lfsr_next(m_lfsr);
        if (model_en && (cyc - 1) >= m_free) begin
          g = -1;
          for (int i = 0; i < N; i++) begin
            s = (m_ptr + i) % N;
            if (g < 0 && respawn_req[s] && !((cyc - 1) == m_mask_cyc && s == m_mask_slot)) g = s;
          end
          if (g >= 0) begin
            r = int'(m_lfsr[7:0]);
            t = ref_type(m_level, r);
            if (t == 4 && m_last == 4) t = 0;
            m_last = t;
            push_exp(g, t, cyc + 1);
            m_ptr = (g + 1) % N;
            m_free = cyc + 2;
            m_mask_cyc = cyc + 2;
            m_mask_slot = g;
          end
        end
      end
    end
  end

  // Monitor: compares every presented issue against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      check("level", level, m_level);
      check("type_table", type_table, pack_tbl());
      if (type_valid || respawn_ack != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", {type_valid, respawn_ack}, 0);
        end else begin
          e = exp_q.pop_front();
          check("type_valid", type_valid, 1);
          check("slot_idx", slot_idx, e.slot);
          check("type_trigger", type_trigger, e.typ);
          check("respawn_ack", respawn_ack, 1 << e.slot);
          if (e.cyc >= 0) check("issue_cycle", cyc, e.cyc);
          exp_table[e.slot] = e.typ;
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc >= 0 && cyc >= exp_q[0].cyc) begin
        check("issue_missing", type_valid, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic hit_reset();
    Reset_n = 1'b0; respawn_req = '0; frame_tick = 1'b0; score = '0;
    exp_q.delete();
    model_reset();
    for (int i = 0; i < N; i++) exp_table[i] = 0;
    #1;
    check("rst_valid", type_valid, 0);
    check("rst_ack", respawn_ack, 0);
    check("rst_slot", slot_idx, 0);
    check("rst_type", type_trigger, 0);
    check("rst_table", type_table, 0);
    check("rst_level", level, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    hit_reset();
  endtask

  task automatic tick();
    @(posedge Clk); #1 frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_ack(input int maxc);
    int n = 0;
    do begin
      @(posedge Clk); #1; n++;
    end while (respawn_ack == '0 && n < maxc);
    check("ack_seen", respawn_ack != '0, 1);
    respawn_req = respawn_req & ~respawn_ack;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge Clk); n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_random(input int ncyc);
    logic [N-1:0] acked;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge Clk); #1;
      acked = respawn_ack;
      respawn_req = respawn_req & ~acked;
      for (int s = 0; s < N; s++) begin
        if (!respawn_req[s] && !acked[s] && $urandom_range(0, 99) < 15) respawn_req[s] = 1'b1;
        else if (respawn_req[s] && $urandom_range(0, 199) == 0) respawn_req[s] = 1'b0;
      end
      frame_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) score = score + 16'($urandom_range(0, 4));
    end
    @(posedge Clk); #1 respawn_req = '0; frame_tick = 1'b0;
    drain(20);
  endtask

  initial begin
    for (int i = 0; i < N; i++) exp_table[i] = 0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Level: 499 never crosses; 1600 steps one level per tick and saturates.
    score = 16'd499;
    repeat (3) tick();
    check("level_499", level, 0);
    score = 16'd1600;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("level_step", level, (k > 3) ? 3 : k);
    end

    // Single request at level 0: latency via the scoreboard, legal L0 type.
    do_reset();
    respawn_req[3] = 1'b1;
    wait_ack(10);
    check("l0_type_legal", (type_trigger == 3'd1 || type_trigger == 3'd4), 0);
    drain(10);

    // All slots held: round-robin 0..9,0; then one slot held shows the post-ack mask.
    do_reset();
    respawn_req = '1;
    repeat (33) @(posedge Clk);
    #1 respawn_req = '0;
    drain(10);
    respawn_req[7] = 1'b1;
    repeat (16) @(posedge Clk);
    #1 respawn_req = '0;
    drain(10);

    // Level crossing in the ack cycle: issued type still uses the old level.
    do_reset();
    score = 16'd499;
    respawn_req[2] = 1'b1;
    wait_ack(10);
    frame_tick = 1'b1; score = 16'd500;
    @(posedge Clk); #1 frame_tick = 1'b0;
    check("level_after_ack_tick", level, 1);
    drain(10);

    // Random traffic, a reset during ISSUE, then more random traffic.
    do_reset();
    run_random(3000);
    for (int i = 0; i < N; i++) respawn_req[i] = 1'b1;
    begin
      int n = 0;
      do begin
        @(posedge Clk); #1; n++;
      end while (!type_valid && n < 20);
      check("found_issue", type_valid, 1);
      hit_reset();
    end
    run_random(3000);

    // Forced roll r=200 at level 2: Brown, then Green (no consecutive Brown).
    do_reset();
    score = 16'd1000;
    tick();
    tick();
    check("level_2", level, 2);
    model_en = 1'b0;
    force dut.lfsr_r = 16'h00C8;
    push_exp(3, 4, -1);
    respawn_req[3] = 1'b1;
    wait_ack(10);
    drain(10);
    push_exp(5, 0, -1);
    respawn_req[5] = 1'b1;
    wait_ack(10);
    drain(10);
    release dut.lfsr_r;
    model_en = 1'b1;
    do_reset();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
